// File: rtl/pc_fetch_pkg.sv
// Shared widths and branch condition-code encodings for the fetch stage.
package pc_fetch_pkg;

  localparam int IM_AW  = 14;
  localparam int PC_W   = 32;
  localparam int PERF_W = 32;

  // Warm-up count at which the un-reset ID_EX controls become trustworthy.
  localparam logic [1:0] WARM_DONE = 2'd2;

  typedef enum logic [2:0] {
    CC_EQ     = 3'b000,
    CC_NEQ    = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GTE    = 3'b100,
    CC_LTE    = 3'b101,
    CC_OVFL   = 3'b110,
    CC_UNCOND = 3'b111
  } cc_e;

endpackage

// File: rtl/pc_fetch_if.sv
// Decode/EX-side control and result signals of the fetch stage.
interface pc_fetch_if;
  import pc_fetch_pkg::*;

  logic              stall_IM_ID;
  logic              stall_ID_EX;
  logic              br_instr_ID_EX;
  logic              jmp_imm_ID_EX;
  logic              jmp_reg_ID_EX;
  logic [2:0]        cc_ID_EX;
  logic              zr;
  logic              neg;
  logic              ov;
  logic [PC_W-1:0]   dst_ID_EX;
  logic [IM_AW-1:0]  iaddr;
  logic [PC_W-1:0]   nxt_pc_ID_EX;
  logic              flow_change_ID_EX;
  logic [PERF_W-1:0] fetch_cnt;
  logic [PERF_W-1:0] taken_cnt;

  modport master (
    output stall_IM_ID, stall_ID_EX, br_instr_ID_EX, jmp_imm_ID_EX, jmp_reg_ID_EX,
           cc_ID_EX, zr, neg, ov, dst_ID_EX,
    input  iaddr, nxt_pc_ID_EX, flow_change_ID_EX, fetch_cnt, taken_cnt
  );

  modport slave (
    input  stall_IM_ID, stall_ID_EX, br_instr_ID_EX, jmp_imm_ID_EX, jmp_reg_ID_EX,
           cc_ID_EX, zr, neg, ov, dst_ID_EX,
    output iaddr, nxt_pc_ID_EX, flow_change_ID_EX, fetch_cnt, taken_cnt
  );

endinterface

// File: rtl/pc_fetch_br_bool.sv
// Branch condition evaluator: maps condition code and flags to a taken decision.
module pc_fetch_br_bool
  import pc_fetch_pkg::*;
(
  input  cc_e  cc,
  input  logic zr,
  input  logic neg,
  input  logic ov,
  output logic taken
);

  always_comb begin
    // NOTE: default first so every path assigns taken and no latch is inferred.
    taken = 1'b0;
    unique case (cc)
      CC_EQ:     taken = zr;
      CC_NEQ:    taken = !zr;
      CC_GT:     taken = !zr && !neg;
      CC_LT:     taken = neg;
      CC_GTE:    taken = zr || !neg;
      CC_LTE:    taken = neg || zr;
      CC_OVFL:   taken = ov;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: owns the PC, drives the IM address, pipelines PC+1 to EX and
// redirects on a taken branch or jump resolved in EX.
module pc_fetch
  import pc_fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  pc_fetch_if.slave bus
);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   nxt_pc_im_id_q, nxt_pc_im_id_d;
  logic [PC_W-1:0]   nxt_pc_id_ex_q, nxt_pc_id_ex_d;
  logic [1:0]        warm_q, warm_d;
  logic [PERF_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [PERF_W-1:0] taken_cnt_q, taken_cnt_d;

  logic armed;
  logic taken;
  logic flow_change;

  pc_fetch_br_bool u_br_bool (
    .cc    (cc_e'(bus.cc_ID_EX)),
    .zr    (bus.zr),
    .neg   (bus.neg),
    .ov    (bus.ov),
    .taken (taken)
  );

  // The ID_EX control flops upstream are not reset, so ignore them until two
  // clocks of valid pipeline have passed since reset.
  assign armed       = (warm_q == WARM_DONE);
  assign flow_change = armed &&
                       (bus.jmp_imm_ID_EX || bus.jmp_reg_ID_EX ||
                        (bus.br_instr_ID_EX && taken));

  always_comb begin
    pc_d           = pc_q;
    nxt_pc_im_id_d = nxt_pc_im_id_q;
    nxt_pc_id_ex_d = nxt_pc_id_ex_q;
    warm_d         = armed ? warm_q : warm_q + 2'd1;
    fetch_cnt_d    = fetch_cnt_q;
    taken_cnt_d    = taken_cnt_q;

    // A redirect wins over a fetch stall so a halted front end can still jump.
    if (flow_change) begin
      pc_d        = bus.dst_ID_EX;
      taken_cnt_d = taken_cnt_q + PERF_W'(1);
    end else if (!bus.stall_IM_ID) begin
      pc_d = pc_q + PC_W'(1);
    end

    if (!bus.stall_IM_ID) begin
      nxt_pc_im_id_d = pc_q + PC_W'(1);
      if (!flow_change && armed) begin
        fetch_cnt_d = fetch_cnt_q + PERF_W'(1);
      end
    end

    if (!bus.stall_ID_EX) begin
      nxt_pc_id_ex_d = nxt_pc_im_id_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      pc_q           <= '0;
      nxt_pc_im_id_q <= '0;
      nxt_pc_id_ex_q <= '0;
      warm_q         <= '0;
      fetch_cnt_q    <= '0;
      taken_cnt_q    <= '0;
    end else begin
      pc_q           <= pc_d;
      nxt_pc_im_id_q <= nxt_pc_im_id_d;
      nxt_pc_id_ex_q <= nxt_pc_id_ex_d;
      warm_q         <= warm_d;
      fetch_cnt_q    <= fetch_cnt_d;
      taken_cnt_q    <= taken_cnt_d;
    end
  end

  assign bus.iaddr             = pc_q[IM_AW-1:0];
  assign bus.nxt_pc_ID_EX      = nxt_pc_id_ex_q;
  assign bus.flow_change_ID_EX = flow_change;
  assign bus.fetch_cnt         = fetch_cnt_q;
  assign bus.taken_cnt         = taken_cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus random traffic,
// compared each cycle against a cycle-level reference model.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  pc_fetch_if bus();

  pc_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [PC_W-1:0]   m_pc, m_nxt_im, m_nxt_ex;
  int                m_cycles;
  logic [PERF_W-1:0] m_fetch, m_taken;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_met(int cc, bit zr, bit neg, bit ov);
    case (cc)
      0: return zr;
      1: return !zr;
      2: return !zr && !neg;
      3: return neg;
      4: return zr || !neg;
      5: return neg || zr;
      6: return ov;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit model_flow();
    bit armed;
    armed = (m_cycles >= 2);
    return armed && (bus.jmp_imm_ID_EX || bus.jmp_reg_ID_EX ||
                     (bus.br_instr_ID_EX &&
                      cond_met(int'(bus.cc_ID_EX), bus.zr, bus.neg, bus.ov)));
  endfunction

  task automatic model_reset();
    m_pc     = '0;
    m_nxt_im = '0;
    m_nxt_ex = '0;
    m_cycles = 0;
    m_fetch  = '0;
    m_taken  = '0;
  endtask

  task automatic idle_inputs();
    bus.stall_IM_ID    = 1'b0;
    bus.stall_ID_EX    = 1'b0;
    bus.br_instr_ID_EX = 1'b0;
    bus.jmp_imm_ID_EX  = 1'b0;
    bus.jmp_reg_ID_EX  = 1'b0;
    bus.cc_ID_EX       = 3'd0;
    bus.zr             = 1'b0;
    bus.neg            = 1'b0;
    bus.ov             = 1'b0;
    bus.dst_ID_EX      = '0;
  endtask

  // Check outputs mid-cycle, then advance one clock and update the model.
  task automatic step();
    bit flow;
    @(negedge clk);
    flow = model_flow();
    check("iaddr",       64'(bus.iaddr),             64'(m_pc[IM_AW-1:0]));
    check("nxt_pc_ID_EX", 64'(bus.nxt_pc_ID_EX),     64'(m_nxt_ex));
    check("flow_change", 64'(bus.flow_change_ID_EX), 64'(flow));
    check("fetch_cnt",   64'(bus.fetch_cnt),         64'(m_fetch));
    check("taken_cnt",   64'(bus.taken_cnt),         64'(m_taken));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!bus.stall_ID_EX) m_nxt_ex = m_nxt_im;
      if (!bus.stall_IM_ID) m_nxt_im = m_pc + 1;
      if (!bus.stall_IM_ID && !flow && m_cycles >= 2) m_fetch = m_fetch + 1;
      if (flow) m_taken = m_taken + 1;
      if (flow)                  m_pc = bus.dst_ID_EX;
      else if (!bus.stall_IM_ID) m_pc = m_pc + 1;
      if (m_cycles < 2) m_cycles++;
    end
    #1;
  endtask

  initial begin
    logic [PERF_W-1:0] fetch_before;
    logic [PERF_W-1:0] taken_before;

    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held, with a would-be taken branch present on the un-reset controls
    bus.br_instr_ID_EX = 1'b1;
    bus.cc_ID_EX       = 3'd7;
    bus.dst_ID_EX      = 32'h0000_0077;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    bus.br_instr_ID_EX = 1'b0;
    step();
    step();
    check("iaddr_after_warmup", 64'(bus.iaddr), 64'd4);

    // Stall for three cycles at iaddr=4
    fetch_before = bus.fetch_cnt;
    bus.stall_IM_ID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_iaddr_hold", 64'(bus.iaddr), 64'd4);
    end
    check("stall_fetch_delta", 64'(bus.fetch_cnt - fetch_before), 64'd0);
    bus.stall_IM_ID = 1'b0;
    step();
    check("stall_resume", 64'(bus.iaddr), 64'd5);
    step();
    step();

    // Branch truth-table sweep
    for (int cc = 0; cc < 8; cc++) begin
      for (int f = 0; f < 8; f++) begin
        bus.br_instr_ID_EX = 1'b1;
        bus.cc_ID_EX       = 3'(cc);
        bus.zr             = f[2];
        bus.neg            = f[1];
        bus.ov             = f[0];
        bus.dst_ID_EX      = 32'h0000_0040;
        step();
        idle_inputs();
        if (cond_met(cc, f[2], f[1], f[0]))
          check("br_target", 64'(bus.iaddr), 64'h40);
        step();
      end
    end

    // Register jump while the front end is stalled
    taken_before = bus.taken_cnt;
    bus.stall_IM_ID   = 1'b1;
    bus.jmp_reg_ID_EX = 1'b1;
    bus.dst_ID_EX     = 32'h0000_1234;
    step();
    idle_inputs();
    check("jmp_reg_iaddr", 64'(bus.iaddr), 64'h1234);
    check("jmp_reg_taken_delta", 64'(bus.taken_cnt - taken_before), 64'd1);
    step();

    // PC wrap from all-ones
    bus.jmp_imm_ID_EX = 1'b1;
    bus.dst_ID_EX     = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    check("wrap_pre", 64'(bus.iaddr), 64'h3FFF);
    step();
    check("wrap_iaddr", 64'(bus.iaddr), 64'd0);
    step();

    // Reset coinciding with a jump
    bus.jmp_imm_ID_EX = 1'b1;
    bus.dst_ID_EX     = 32'h0000_0080;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_iaddr", 64'(bus.iaddr), 64'd0);
    check("midrst_fetch", 64'(bus.fetch_cnt), 64'd0);
    check("midrst_taken", 64'(bus.taken_cnt), 64'd0);
    step();
    step();
    idle_inputs();
    step();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.stall_IM_ID    = ($urandom_range(0, 3) == 0);
      bus.stall_ID_EX    = ($urandom_range(0, 3) == 0);
      bus.br_instr_ID_EX = ($urandom_range(0, 3) == 0);
      bus.jmp_imm_ID_EX  = ($urandom_range(0, 15) == 0);
      bus.jmp_reg_ID_EX  = ($urandom_range(0, 15) == 0);
      bus.cc_ID_EX       = 3'($urandom_range(0, 7));
      bus.zr             = 1'($urandom);
      bus.neg            = 1'($urandom);
      bus.ov             = 1'($urandom);
      bus.dst_ID_EX      = $urandom;
      rst_n              = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1'b1;
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
